// File: rtl/alu_pkg.sv
// Opcode and FSM-state encodings shared by the sequential ALU, plus the issue-time
// decision of whether an operation needs the iterative BUSY path.
package alu_pkg;

   localparam logic [3:0] OP_AND  = 4'b0000;
   localparam logic [3:0] OP_OR   = 4'b0001;
   localparam logic [3:0] OP_ADD  = 4'b0010;
   localparam logic [3:0] OP_XOR  = 4'b0011;
   localparam logic [3:0] OP_SUB  = 4'b0110;
   localparam logic [3:0] OP_SLT  = 4'b0111;
   localparam logic [3:0] OP_SLTU = 4'b1000;
   localparam logic [3:0] OP_SLL  = 4'b1001;
   localparam logic [3:0] OP_SRL  = 4'b1010;
   localparam logic [3:0] OP_SRA  = 4'b1011;
   localparam logic [3:0] OP_MUL  = 4'b1100;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_BUSY = 2'd1;
   localparam logic [1:0] ST_HOLD = 2'd2;

   // A shift by zero is finished at issue, so only nonzero shifts and MUL iterate.
   function automatic logic is_multicycle(input logic [3:0] s, input logic [31:0] shamt);
      return (s == OP_MUL) ||
             (((s == OP_SLL) || (s == OP_SRL) || (s == OP_SRA)) && (shamt != 32'd0));
   endfunction

endpackage

// File: rtl/rca_cout.sv
// n-bit ripple-carry adder with carry-in and carry-out; purely combinational.
module rca_cout #(
   parameter int n = 32
) (
   input  logic [n-1:0] a_i,
   input  logic [n-1:0] b_i,
   input  logic         cin_i,
   output logic [n-1:0] sum_o,
   output logic         cout_o
);

   logic [n:0] carry;

   always_comb begin
      carry    = '0;
      sum_o    = '0;
      carry[0] = cin_i;
      for (int i = 0; i < n; i++) begin
         sum_o[i]     = a_i[i] ^ b_i[i] ^ carry[i];
         carry[i+1]   = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
      end
      cout_o = carry[n];
   end

endmodule

// File: rtl/n_bit_seq_alu.sv
// Registered valid/ready ALU: logic/arith ops in 1 cycle, shifts 1 bit/cycle, MUL n-cycle shift-add.
// Result and flags are held in HOLD until out_ready; in_ready is low throughout BUSY.
module n_bit_seq_alu
   import alu_pkg::*;
#(
   parameter int n = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [n-1:0] A,
   input  logic [n-1:0] B,
   input  logic [3:0]   S,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [n-1:0] ALUoutput,
   output logic         Zflag,
   output logic         Nflag,
   output logic         Cflag,
   output logic         Vflag,
   output logic         illegal
);

   localparam int SH_W = $clog2(n);
   localparam int CW   = SH_W + 1;

   logic [1:0]    state_q, state_d;
   logic [3:0]    op_q, op_d;
   logic [n-1:0]  work_q, work_d;
   logic [n-1:0]  mplier_q, mplier_d;
   logic [n-1:0]  acc_q, acc_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [n-1:0]  res_q, res_d;
   logic          zf_q, zf_d, nf_q, nf_d, cf_q, cf_d, vf_q, vf_d, ill_q, ill_d;

   logic [SH_W-1:0] shamt;
   logic            accept, is_sub;
   logic [n-1:0]    add_a, add_b, sum;
   logic            add_cin, cout, v_add;
   logic            commit, c_new, v_new, ill_new;
   logic [n-1:0]    res_new, fin_val;

   assign shamt     = B[SH_W-1:0];
   assign in_ready  = (state_q == ST_IDLE) || ((state_q == ST_HOLD) && out_ready);
   assign out_valid = (state_q == ST_HOLD);
   assign accept    = in_valid && in_ready;
   assign is_sub    = (S == OP_SUB) || (S == OP_SLT) || (S == OP_SLTU);

   // The single adder serves operand arithmetic at issue and the MUL accumulator while BUSY.
   always_comb begin
      if (state_q == ST_BUSY) begin
         add_a   = acc_q;
         add_b   = work_q;
         add_cin = 1'b0;
      end else begin
         add_a   = A;
         add_b   = is_sub ? ~B : B;
         add_cin = is_sub;
      end
   end

   rca_cout #(.n(n)) u_add (
      .a_i    (add_a),
      .b_i    (add_b),
      .cin_i  (add_cin),
      .sum_o  (sum),
      .cout_o (cout)
   );

   assign v_add = (A[n-1] == add_b[n-1]) && (sum[n-1] != A[n-1]);

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      work_d   = work_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      commit   = 1'b0;
      res_new  = '0;
      fin_val  = '0;
      c_new    = 1'b0;
      v_new    = 1'b0;
      ill_new  = 1'b0;

      if (state_q == ST_BUSY) begin
         if (op_q == OP_MUL) begin
            if (mplier_q[0]) acc_d = sum;
            work_d   = work_q << 1;
            mplier_d = mplier_q >> 1;
            fin_val  = mplier_q[0] ? sum : acc_q;
         end else begin
            case (op_q)
               OP_SLL:  work_d = work_q << 1;
               OP_SRL:  work_d = work_q >> 1;
               default: work_d = {work_q[n-1], work_q[n-1:1]};
            endcase
            fin_val = work_d;
         end
         cnt_d = cnt_q - 1'b1;
         if (cnt_q == CW'(1)) begin
            commit  = 1'b1;
            res_new = fin_val;
            state_d = ST_HOLD;
         end
      end else begin
         state_d = ((state_q == ST_HOLD) && !out_ready) ? ST_HOLD : ST_IDLE;
         if (accept) begin
            op_d = S;
            if (is_multicycle(S, 32'(shamt))) begin
               state_d  = ST_BUSY;
               work_d   = A;
               mplier_d = B;
               acc_d    = '0;
               cnt_d    = (S == OP_MUL) ? CW'(n) : {1'b0, shamt};
            end else begin
               state_d = ST_HOLD;
               commit  = 1'b1;
               case (S)
                  OP_AND:  res_new = A & B;
                  OP_OR:   res_new = A | B;
                  OP_XOR:  res_new = A ^ B;
                  OP_ADD, OP_SUB: begin
                     res_new = sum;
                     c_new   = cout;
                     v_new   = v_add;
                  end
                  OP_SLT:  res_new = {{(n-1){1'b0}}, sum[n-1] ^ v_add};
                  OP_SLTU: res_new = {{(n-1){1'b0}}, ~cout};
                  OP_SLL, OP_SRL, OP_SRA: res_new = A;
                  default: ill_new = 1'b1;
               endcase
            end
         end
      end

      res_d = res_q;
      zf_d  = zf_q;
      nf_d  = nf_q;
      cf_d  = cf_q;
      vf_d  = vf_q;
      ill_d = ill_q;
      if (commit) begin
         res_d = res_new;
         zf_d  = (res_new == '0);
         nf_d  = res_new[n-1];
         cf_d  = c_new;
         vf_d  = v_new;
         ill_d = ill_new;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         op_q     <= '0;
         work_q   <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         res_q    <= '0;
         zf_q     <= 1'b0;
         nf_q     <= 1'b0;
         cf_q     <= 1'b0;
         vf_q     <= 1'b0;
         ill_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         work_q   <= work_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         res_q    <= res_d;
         zf_q     <= zf_d;
         nf_q     <= nf_d;
         cf_q     <= cf_d;
         vf_q     <= vf_d;
         ill_q    <= ill_d;
      end
   end

   assign ALUoutput = res_q;
   assign Zflag     = zf_q;
   assign Nflag     = nf_q;
   assign Cflag     = cf_q;
   assign Vflag     = vf_q;
   assign illegal   = ill_q;

endmodule

// File: tb/tb_n_bit_seq_alu.sv
// Directed bench for n_bit_seq_alu: a cycle-level behavioural model checked every cycle,
// plus literal expectations for the headline vectors.
module tb_n_bit_seq_alu;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] A = '0;
   logic [31:0] B = '0;
   logic [3:0]  S = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] ALUoutput;
   logic        Zflag, Nflag, Cflag, Vflag, illegal;

   int errors = 0;
   int checks = 0;

   n_bit_seq_alu #(.n(32)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .A(A), .B(B), .S(S), .out_valid(out_valid), .out_ready(out_ready),
      .ALUoutput(ALUoutput), .Zflag(Zflag), .Nflag(Nflag), .Cflag(Cflag),
      .Vflag(Vflag), .illegal(illegal)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] r;
      logic z, nf, c, v, ill;
   } exp_t;

   function automatic exp_t ref_op(input logic [3:0] s, input logic [31:0] a, input logic [31:0] b);
      exp_t   e;
      longint sa, sb, t;
      logic [32:0] w;
      logic [4:0]  k;
      e  = '0;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      k  = b[4:0];
      case (s)
         4'b0000: e.r = a & b;
         4'b0001: e.r = a | b;
         4'b0011: e.r = a ^ b;
         4'b0010: begin
            w = {1'b0, a} + {1'b0, b};
            e.r = w[31:0]; e.c = w[32];
            t = sa + sb;
            e.v = (t > longint'(32'sh7FFFFFFF)) || (t < -longint'(64'sh80000000));
         end
         4'b0110: begin
            e.r = a - b; e.c = (a >= b);
            t = sa - sb;
            e.v = (t > longint'(32'sh7FFFFFFF)) || (t < -longint'(64'sh80000000));
         end
         4'b0111: e.r = (sa < sb) ? 32'd1 : 32'd0;
         4'b1000: e.r = (a < b) ? 32'd1 : 32'd0;
         4'b1001: e.r = a << k;
         4'b1010: e.r = a >> k;
         4'b1011: e.r = 32'($signed(a) >>> k);
         4'b1100: e.r = a * b;
         default: e.ill = 1'b1;
      endcase
      e.z  = (e.r == 32'd0);
      e.nf = e.r[31];
      return e;
   endfunction

   function automatic int lat_of(input logic [3:0] s, input logic [31:0] b);
      logic [4:0] k;
      k = b[4:0];
      if (s == 4'b1100) return 33;
      if ((s == 4'b1001) || (s == 4'b1010) || (s == 4'b1011)) return int'(k) + 1;
      return 1;
   endfunction

   // Model: cycles left until the result appears, and whether a result is being held.
   int   m_wait  = 0;
   bit   m_valid = 1'b0;
   exp_t m_cur   = '0;

   function automatic bit m_rdy();
      return (m_wait == 0) && (!m_valid || out_ready);
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_wait  <= 0;
         m_valid <= 1'b0;
      end else if (m_wait > 0) begin
         m_wait  <= m_wait - 1;
         m_valid <= (m_wait == 1);
      end else if (in_valid && m_rdy()) begin
         m_cur   <= ref_op(S, A, B);
         m_valid <= (lat_of(S, B) == 1);
         m_wait  <= lat_of(S, B) - 1;
      end else if (out_ready) begin
         m_valid <= 1'b0;
      end
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         chk("model.in_ready", 64'(in_ready), 64'(m_rdy()));
         chk("model.out_valid", 64'(out_valid), 64'(m_valid));
         if (m_valid && out_valid) begin
            chk("model.result", 64'(ALUoutput), 64'(m_cur.r));
            chk("model.flags", 64'({Zflag, Nflag, Cflag, Vflag, illegal}),
                64'({m_cur.z, m_cur.nf, m_cur.c, m_cur.v, m_cur.ill}));
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [3:0] s, input logic [31:0] a, input logic [31:0] b);
      in_valid = 1'b1; S = s; A = a; B = b;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (in_ready) begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            return;
         end
      end
      in_valid = 1'b0;
      chk("issue.timeout", 64'd1, 64'd0);
   endtask

   task automatic wait_result(output int lat, output int busy);
      lat = 0; busy = 0;
      while (lat < 100) begin
         @(negedge clk);
         lat++;
         if (out_valid) return;
         if (!in_ready) busy++;
      end
      chk("result.timeout", 64'd1, 64'd0);
   endtask

   task automatic run(input string nm, input logic [3:0] s, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] er, input logic [4:0] ef,
                      input int elat);
      int lat, busy;
      step();
      issue(s, a, b);
      wait_result(lat, busy);
      chk({nm, ".lat"}, 64'(lat), 64'(elat));
      chk({nm, ".res"}, 64'(ALUoutput), 64'(er));
      chk({nm, ".flags"}, 64'({Zflag, Nflag, Cflag, Vflag, illegal}), 64'(ef));
   endtask

   initial begin
      int lat, busy;
      #1 rst_n = 1'b0;
      #3;
      chk("rst.in_ready", 64'(in_ready), 64'd1);
      chk("rst.out_valid", 64'(out_valid), 64'd0);
      chk("rst.outputs", 64'({ALUoutput, Zflag, Nflag, Cflag, Vflag, illegal}), 64'd0);
      @(posedge clk); #2 rst_n = 1'b1;

      //                                           result        Z N C V I   lat
      run("add",  4'b0010, 32'h7FFFFFFF, 32'd1, 32'h80000000, 5'b01010, 1);
      run("sub",  4'b0110, 32'd5,        32'd5, 32'd0,        5'b10100, 1);
      run("slt",  4'b0111, 32'hFFFFFFFF, 32'd1, 32'd1,        5'b00000, 1);
      run("sltu", 4'b1000, 32'hFFFFFFFF, 32'd1, 32'd0,        5'b10000, 1);

      step();
      issue(4'b1011, 32'h80000000, 32'd4);
      wait_result(lat, busy);
      chk("sra.lat", 64'(lat), 64'd5);
      chk("sra.busy", 64'(busy), 64'd4);
      chk("sra.res", 64'(ALUoutput), 64'hF8000000);

      run("sll0", 4'b1001, 32'h12345678, 32'd32, 32'h12345678, 5'b00000, 1);
      run("mul",  4'b1100, 32'h00010003, 32'd7,  32'h00070015, 5'b00000, 33);
      run("mulw", 4'b1100, 32'hFFFFFFFF, 32'd2,  32'hFFFFFFFE, 5'b01000, 33);

      // Backpressure: hold an AND result, then drain it while issuing OR.
      step();
      out_ready = 1'b0;
      issue(4'b0000, 32'h0000F0F0, 32'h0000FF00);
      wait_result(lat, busy);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp.res", 64'(ALUoutput), 64'h0000F000);
         chk("bp.hold", 64'({out_valid, in_ready}), 64'b10);
      end
      step();
      out_ready = 1'b1;
      issue(4'b0001, 32'h0000F0F0, 32'h0000FF00);
      wait_result(lat, busy);
      chk("bp.or_lat", 64'(lat), 64'd1);
      chk("bp.or_res", 64'(ALUoutput), 64'h0000FFF0);

      run("illegal", 4'b1111, 32'h1234, 32'h5678, 32'd0, 5'b10001, 1);

      // Model-only vectors covering the remaining ops and edge cases.
      run("xor",   4'b0011, 32'hA5A5A5A5, 32'hFFFF0000, 32'h5A5AA5A5, 5'b00000, 1);
      run("srl31", 4'b1010, 32'h80000001, 32'hFFFFFFFF, 32'd1,        5'b00000, 32);
      run("sll5",  4'b1001, 32'd1,        32'h45,       32'h20,       5'b00000, 6);
      run("subv",  4'b0110, 32'h80000000, 32'd1,        32'h7FFFFFFF, 5'b00110, 1);
      run("addc",  4'b0010, 32'hFFFFFFFF, 32'd1,        32'd0,        5'b10100, 1);
      run("sltn",  4'b0111, 32'h80000000, 32'h7FFFFFFF, 32'd1,        5'b00000, 1);

      // Reset in the middle of a MUL discards it.
      step();
      issue(4'b1100, 32'd3, 32'd5);
      repeat (10) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst.out_valid", 64'(out_valid), 64'd0);
      chk("midrst.in_ready", 64'(in_ready), 64'd1);
      @(posedge clk); #2 rst_n = 1'b1;
      run("add_after_rst", 4'b0010, 32'd2, 32'd3, 32'd5, 5'b00000, 1);

      repeat (3) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/n_bit_seq_alu.md
Name: n_bit_seq_alu

Overview:
Registered, handshaked successor to the combinational N-bit ALU; it sits between operand fetch and writeback in the multi-cycle datapath.
- Single-cycle ops (AND/OR/XOR/ADD/SUB/SLT/SLTU) complete with 1-cycle latency.
- Shifts run iteratively at 1 bit per cycle; MUL runs as an N-cycle shift-add.
- Result and Z/N/C/V flags are registered and held until the consumer accepts them.

Parameters:
- n, 32, operand/result width. Must be a power of two and ≥ 4.
- SH_W, $clog2(n), derived localparam: width of the shift amount taken from B[SH_W-1:0].

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operands and opcode are valid.
- in_ready  out  1  the block can accept an operation this cycle.
- A  in  n  operand A.
- B  in  n  operand B; for shifts, B[SH_W-1:0] is the shift amount.
- S  in  4  opcode.
- out_valid  out  1  ALUoutput and flags are valid.
- out_ready  in  1  consumer accepts the result.
- ALUoutput  out  n  registered result.
- Zflag  out  1  result == 0.
- Nflag  out  1  result[n-1].
- Cflag  out  1  ADD: carry out. SUB: not-borrow (carry out of A + ~B + 1). All other ops: 0.
- Vflag  out  1  signed overflow for ADD/SUB; all other ops: 0.
- illegal  out  1  the held result came from an unassigned opcode.

Behaviour:
- Opcodes:
  - 0000 AND, 0001 OR, 0010 ADD, 0110 SUB (encodings unchanged from the combinational ALU).
  - 0011 XOR.
  - 0111 SLT (signed): result is {0…,1} if A<B, else 0.
  - 1000 SLTU (unsigned), same result format.
  - 1001 SLL, 1010 SRL, 1011 SRA.
  - 1100 MUL: low n bits of A*B.
  - All others are illegal: result 0, Zflag 1, illegal 1, latency 1.
- States: IDLE, BUSY, HOLD.
  - Accept = in_valid && in_ready; operands and opcode are captured on the accepting edge.
  - in_ready = (state==IDLE) || (state==HOLD && out_ready). Back-to-back issue is allowed when the consumer drains in the same cycle.
  - Single-cycle op, or shift with amount 0: accepting edge → HOLD, out_valid=1 next cycle (latency 1).
  - Shift with amount k>0: → BUSY. Shift by 1 per cycle, with SRA replicating the MSB. Count down k; the final iteration → HOLD. out_valid rises k+1 cycles after accept.
  - MUL: → BUSY for n iterations. Each iteration: if multiplier LSB is set, add multiplicand to the accumulator, then shift multiplicand left and multiplier right. → HOLD; out_valid rises n+1 cycles after accept.
  - HOLD: out_valid=1. ALUoutput, all flags and illegal stay stable until out_ready.
    - out_ready && !in_valid → IDLE, out_valid=0.
    - out_ready && in_valid → accept the new op. Next state follows the new op (HOLD for a single-cycle op).
- In BUSY:
  - in_ready=0 and out_valid=0.
  - in_valid is ignored; the producer must hold its request.
  - out_ready is ignored.
- Flags are computed from the final result and registered in the same edge as ALUoutput.
- ADD/SUB use one n-bit adder with B inverted and carry-in = 1 for SUB.
  - V = (A[n-1]==Bmux[n-1]) && (sum[n-1]!=A[n-1]).
  - SLT uses sum[n-1] ^ V from the SUB path; SLTU uses !C from the SUB path.
- Reset, asynchronous, any state including mid-BUSY:
  - State → IDLE; the in-flight op is discarded.
  - out_valid=0, ALUoutput=0, all flags=0, illegal=0.
  - in_ready is 1 while rst_n is low.
- Shift amount uses only B[SH_W-1:0]; the upper bits of B are ignored.
- MUL overflow is discarded silently: C=V=0. Z and N reflect the truncated result.

Decomposition:
- Package alu_pkg holds:
  - localparams for all 4-bit opcodes;
  - state encoding IDLE/BUSY/HOLD;
  - a function is_multicycle(S, shamt).
- One sub-module, rca_cout: an n-bit ripple-carry adder with carry-in and carry-out.
  - Instantiated once for ADD/SUB/SLT/SLTU.
  - Reused as the MUL accumulator adder; the operand mux is selected by state.

Test Plan:
- Reset, then ADD A=0x7FFFFFFF B=1, out_ready=1 → 1 cycle later: ALUoutput 0x80000000, N=1, V=1, C=0, Z=0.
- SUB A=5 B=5 → result 0, Z=1, C=1, V=0. Then SLT A=0xFFFFFFFF (−1) B=1 → 1. SLTU with the same operands → 0.
- SRA A=0x80000000 B=4 → in_ready low for 4 cycles; out_valid 5 cycles after accept; result 0xF8000000. SLL with B=32 (amount 0) → result A, latency 1.
- MUL A=0x0001_0003 B=7 → out_valid n+1=33 cycles after accept; result 0x0007_0015. MUL A=0xFFFFFFFF B=2 → 0xFFFFFFFE, C=V=0.
- Backpressure: out_ready=0 for 5 cycles after an AND result → outputs stable and in_ready=0 throughout. Raise out_ready with in_valid high and an OR op → the OR result appears the next cycle with no bubble.
- Illegal S=1111 → result 0, Z=1, illegal=1. Assert rst_n=0 mid-MUL (cycle 10) → out_valid=0 immediately; after release, a new ADD completes normally.
